// File: rtl/banco_nos_ativos.sv
// Active-node register bank: one-hot insert/relax/deactivate writes and a
// sequential scan that selects the active entry with the lowest distancia + menor_vizinho.
module banco_nos_ativos #(
    parameter int unsigned NUM_NA          = 8,
    parameter int unsigned ADDR_WIDTH      = 5,
    parameter int unsigned DISTANCIA_WIDTH = 5,
    parameter int unsigned CUSTO_WIDTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ga_desativar_in,
    input  logic                         ga_atualizar_in,
    input  logic [NUM_NA-1:0]            ga_habilitar_in,
    input  logic [ADDR_WIDTH-1:0]        ga_endereco_in,
    input  logic [ADDR_WIDTH-1:0]        ga_anterior_in,
    input  logic [CUSTO_WIDTH-1:0]       ga_menor_vizinho_in,
    input  logic [DISTANCIA_WIDTH-1:0]   ga_distancia_in,
    input  logic                         selecionar_in,
    output logic [ADDR_WIDTH*NUM_NA-1:0] bna_endereco_out,
    output logic [NUM_NA-1:0]            bna_ativo_out,
    output logic                         bna_ocupado_o,
    output logic                         bna_valido_o,
    output logic                         bna_vazio_o,
    output logic [NUM_NA-1:0]            bna_menor_indice_o,
    output logic [ADDR_WIDTH-1:0]        bna_menor_endereco_o,
    output logic [ADDR_WIDTH-1:0]        bna_menor_anterior_o,
    output logic [DISTANCIA_WIDTH-1:0]   bna_menor_distancia_o
);
    localparam int unsigned IDX_W = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;
    localparam int unsigned F_W   = DISTANCIA_WIDTH + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NA - 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]      endereco;
        logic [ADDR_WIDTH-1:0]      anterior;
        logic [CUSTO_WIDTH-1:0]     menor_vizinho;
        logic [DISTANCIA_WIDTH-1:0] distancia;
    } entrada_t;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_RESULT} estado_t;

    entrada_t                   entrada_q [NUM_NA];
    entrada_t                   entrada_d [NUM_NA];
    logic [NUM_NA-1:0]          ativo_q, ativo_d;

    estado_t                    state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       best_valid_q, best_valid_d;
    logic [IDX_W-1:0]           best_idx_q, best_idx_d;
    logic [F_W-1:0]             best_f_q, best_f_d;
    entrada_t                   best_q, best_d;

    logic                       ocupado_q, ocupado_d;
    logic                       valido_q, valido_d;
    logic                       vazio_q, vazio_d;
    logic [NUM_NA-1:0]          menor_indice_q, menor_indice_d;
    entrada_t                   menor_q, menor_d;

    entrada_t                   cur_c;
    logic [F_W-1:0]             cur_f_c;

    // Entry write rules: deactivate wins, insert on free entry, relax on shorter distance
    always_comb begin
        ativo_d = ativo_q;
        for (int i = 0; i < NUM_NA; i++) begin
            entrada_d[i] = entrada_q[i];
            if (ga_habilitar_in[i]) begin
                if (ga_desativar_in) begin
                    ativo_d[i] = 1'b0;
                end else if (ga_atualizar_in) begin
                    if (!ativo_q[i]) begin
                        entrada_d[i].endereco      = ga_endereco_in;
                        entrada_d[i].anterior      = ga_anterior_in;
                        entrada_d[i].menor_vizinho = ga_menor_vizinho_in;
                        entrada_d[i].distancia     = ga_distancia_in;
                        ativo_d[i]                 = 1'b1;
                    end else if (ga_distancia_in < entrada_q[i].distancia) begin
                        entrada_d[i].anterior      = ga_anterior_in;
                        entrada_d[i].menor_vizinho = ga_menor_vizinho_in;
                        entrada_d[i].distancia     = ga_distancia_in;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NA; i++) entrada_q[i] <= '0;
            ativo_q <= '0;
        end else begin
            for (int i = 0; i < NUM_NA; i++) entrada_q[i] <= entrada_d[i];
            ativo_q <= ativo_d;
        end
    end

    always_comb begin
        bna_endereco_out = '0;
        for (int i = 0; i < NUM_NA; i++) begin
            bna_endereco_out[ADDR_WIDTH*i +: ADDR_WIDTH] = entrada_q[i].endereco;
        end
    end
    assign bna_ativo_out = ativo_q;

    assign cur_c   = entrada_q[idx_q];
    assign cur_f_c = F_W'(cur_c.distancia) + F_W'(cur_c.menor_vizinho);

    // Scan FSM: next state, best-so-far tracking and result capture
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        best_valid_d   = best_valid_q;
        best_idx_d     = best_idx_q;
        best_f_d       = best_f_q;
        best_d         = best_q;
        valido_d       = 1'b0;
        vazio_d        = 1'b0;
        menor_indice_d = menor_indice_q;
        menor_d        = menor_q;
        case (state_q)
            ST_IDLE: begin
                if (selecionar_in) begin
                    state_d      = ST_SCAN;
                    idx_d        = '0;
                    best_valid_d = 1'b0;
                    best_idx_d   = '0;
                    best_f_d     = '0;
                    best_d       = '0;
                end
            end
            ST_SCAN: begin
                if (|ga_habilitar_in) begin
                    idx_d        = '0;
                    best_valid_d = 1'b0;
                    best_idx_d   = '0;
                    best_f_d     = '0;
                    best_d       = '0;
                end else begin
                    if (ativo_q[idx_q] && (!best_valid_q || (cur_f_c < best_f_q))) begin
                        best_valid_d = 1'b1;
                        best_idx_d   = idx_q;
                        best_f_d     = cur_f_c;
                        best_d       = cur_c;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RESULT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_RESULT: begin
                valido_d       = best_valid_q;
                vazio_d        = !best_valid_q;
                menor_indice_d = best_valid_q ? (NUM_NA'(1) << best_idx_q) : '0;
                menor_d        = best_q;
                state_d        = ST_IDLE;
                idx_d          = '0;
            end
            default: state_d = ST_IDLE;
        endcase
        ocupado_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            best_valid_q   <= 1'b0;
            best_idx_q     <= '0;
            best_f_q       <= '0;
            best_q         <= '0;
            ocupado_q      <= 1'b0;
            valido_q       <= 1'b0;
            vazio_q        <= 1'b0;
            menor_indice_q <= '0;
            menor_q        <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            best_valid_q   <= best_valid_d;
            best_idx_q     <= best_idx_d;
            best_f_q       <= best_f_d;
            best_q         <= best_d;
            ocupado_q      <= ocupado_d;
            valido_q       <= valido_d;
            vazio_q        <= vazio_d;
            menor_indice_q <= menor_indice_d;
            menor_q        <= menor_d;
        end
    end

    assign bna_ocupado_o         = ocupado_q;
    assign bna_valido_o          = valido_q;
    assign bna_vazio_o           = vazio_q;
    assign bna_menor_indice_o    = menor_indice_q;
    assign bna_menor_endereco_o  = menor_q.endereco;
    assign bna_menor_anterior_o  = menor_q.anterior;
    assign bna_menor_distancia_o = menor_q.distancia;

endmodule

// File: doc/banco_nos_ativos.md
# banco_nos_ativos

Register bank holding the NUM_NA active-node (NA) entries of the path-search engine, sitting directly downstream of the active-node manager. It consumes the manager's one-hot enable plus node data to insert, relax or deactivate entries; it feeds back every entry's address and active flag for the manager's hit detection. On request it runs a sequential scan that selects the active entry with the lowest estimated cost, distancia + menor_vizinho, for node expansion.

## Interface
- NUM_NA, 8, number of NA entries
- ADDR_WIDTH, 5, node address width
- DISTANCIA_WIDTH, 5, accumulated distance width (must be ≥ CUSTO_WIDTH)
- CUSTO_WIDTH, 4, neighbour cost/heuristic width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ga_desativar_in  in  1  action qualifier: deactivate enabled entry
- ga_atualizar_in  in  1  action qualifier: insert/relax enabled entry
- ga_habilitar_in  in  NUM_NA  one-cycle one-hot write strobe, bit i selects entry i
- ga_endereco_in  in  ADDR_WIDTH  node address
- ga_anterior_in  in  ADDR_WIDTH  predecessor address
- ga_menor_vizinho_in  in  CUSTO_WIDTH  cheapest-neighbour cost
- ga_distancia_in  in  DISTANCIA_WIDTH  accumulated distance
- selecionar_in  in  1  pulse: start minimum-cost scan
- bna_endereco_out  out  ADDR_WIDTH*NUM_NA  packed entry addresses, entry i at [ADDR_WIDTH*i +: ADDR_WIDTH]
- bna_ativo_out  out  NUM_NA  entry active flags
- bna_ocupado_o  out  1  scan in progress
- bna_valido_o  out  1  one-cycle pulse: minimum found
- bna_vazio_o  out  1  one-cycle pulse: scan found no active entry
- bna_menor_indice_o  out  NUM_NA  one-hot index of selected entry
- bna_menor_endereco_o / bna_menor_anterior_o  out  ADDR_WIDTH  selected entry fields
- bna_menor_distancia_o  out  DISTANCIA_WIDTH  selected entry distance

## Operation
- Entry i stores endereco, anterior, menor_vizinho, distancia, ativo.
- Write, on any edge where ga_habilitar_in[i]=1:
  - ga_desativar_in=1: ativo[i]<=0; other fields untouched. desativar has priority over atualizar.
  - else ga_atualizar_in=1 and ativo[i]=0: load all four fields, ativo[i]<=1.
  - else ga_atualizar_in=1 and ativo[i]=1: relaxation. If ga_distancia_in < stored distancia, replace anterior, distancia and menor_vizinho. Otherwise no change. endereco is never rewritten on an active entry.
  - else: no action.
- Multiple bits set in ga_habilitar_in: every enabled entry is written with the same data. The manager never generates this; the behaviour is still defined.
- Cost: f = distancia + menor_vizinho, zero-extended to DISTANCIA_WIDTH+1 bits, no overflow.
- FSM ST_IDLE → ST_SCAN → ST_RESULT → ST_IDLE:
  - ST_IDLE: selecionar_in=1 → ST_SCAN, idx<=0, best cleared.
  - ST_SCAN: entry idx evaluated each cycle. It is taken if it is active and (no best yet or f < best_f). Ties keep the lower index.
  - ST_SCAN, idx=NUM_NA-1 → ST_RESULT.
  - ST_SCAN, any write strobe in the cycle → idx<=0, best cleared, scan restarts. The restarted scan is the one that reaches ST_RESULT.
  - ST_RESULT: bna_valido_o=1 if a best exists, else bna_vazio_o=1. The menor_* outputs update from best and hold until the next ST_RESULT → ST_IDLE.
- selecionar_in is ignored outside ST_IDLE.
- bna_ocupado_o = (state != ST_IDLE).

## Timing
- Reset: all ativo=0 and all entry fields 0; all outputs 0; state ST_IDLE, idx=0.
- Reset mid-scan aborts immediately, with no result pulse.
- Writes become visible on bna_endereco_out/bna_ativo_out the cycle after the strobe edge.
- Scan latency:
  - selecionar_in sampled at edge 0 → result pulse high in the cycle after edge NUM_NA+1, i.e. NUM_NA+2 cycles from request.
  - Each restart adds cycles equal to the number of entries already scanned.
- Result pulses last exactly one cycle. bna_valido_o and bna_vazio_o are never high together.
- The selected entry's fields are sampled at scan time. A later write does not alter the held menor_* outputs.

## Test plan
- Reset, then idle: bna_ativo_out=0; selecionar_in pulse → bna_vazio_o pulse 10 cycles later (NUM_NA=8); bna_valido_o stays 0.
- Insert addr 3 (d=4, c=2) into entry 0 and addr 7 (d=2, c=1) into entry 5; select → bna_valido_o, bna_menor_indice_o=8'b0010_0000, bna_menor_endereco_o=7, bna_menor_distancia_o=2.
- Relax entry 0 with d=1, anterior=9 → stored d=1, anterior 9; relax again with d=3 → no change; select → entry 0 wins (f=3 < 3? tie on f=3 vs 3 keeps index 0).
- Desativar entry 5 → bna_ativo_out[5]=0, bna_endereco_out entry 5 still 7; select → entry 0 selected.
- Write strobe to entry 2 in the 4th scan cycle → scan restarts, result pulse 4 cycles late, and the result includes entry 2.
- Assert rst_n low mid-scan → bna_ocupado_o=0, all ativo cleared, no result pulse; selecionar_in ignored while bna_ocupado_o=1.
